// File: rtl/sha_msg_padder.sv
// sha_msg_padder: front-end sequencer for a SHA-256 compression core.
// Collects message bytes into 512-bit blocks, appends 0x80 / zero fill / 64-bit
// big-endian bit length, and hands each block to the core over valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    message byte
//   in_valid   in_data valid
//   in_last    in_data is the final message byte
//   in_ready   byte accepted when in_valid & in_ready at the clock edge
//   blk_data   block, byte 0 at [511:504], byte 63 at [7:0]
//   blk_valid  block valid; data and flags stable while high
//   blk_ready  core accepts block when blk_valid & blk_ready at the clock edge
//   blk_first  block is the first of its message
//   blk_last   block is the final one (carries the length field)
//   busy       high from first accepted byte until the final block is accepted
module sha_msg_padder #(
    parameter int unsigned CNT_W = 61
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [511:0]   blk_data,
    output logic           blk_valid,
    input  logic           blk_ready,
    output logic           blk_first,
    output logic           blk_last,
    output logic           busy
);

    localparam int unsigned BLK_BYTES = 64;
    localparam int unsigned IDX_W     = 7;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        PAD80 = 3'd1,
        ZERO  = 3'd2,
        LEN   = 3'd3,
        EMIT  = 3'd4
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         mem [BLK_BYTES];
    logic               first_f;
    logic               pad_pend;   // message filled a block exactly at last byte; 0x80 goes in next block
    logic               final_f;
    logic               pad_act;    // 0x80 written, length not yet written
    logic               len_ok;     // current block has room for the length field

    logic [63:0]        bitlen;
    logic [7:0]         len_byte;

    assign bitlen   = 64'({cnt, 3'b000});
    // ~idx[2:0] == 7 - (idx - 56) for idx in 56..63, selecting MSB byte first
    assign len_byte = 8'(bitlen >> {~idx[2:0], 3'b000});

    // Flatten buffer onto the block bus, byte 0 in the most significant lane
    always_comb begin
        blk_data = '0;
        for (int i = 0; i < 64; i++) begin
            blk_data[511-8*i -: 8] = mem[i];
        end
    end

    // Sequencer with registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            idx       <= '0;
            cnt       <= '0;
            first_f   <= 1'b1;
            pad_pend  <= 1'b0;
            final_f   <= 1'b0;
            pad_act   <= 1'b0;
            len_ok    <= 1'b0;
            in_ready  <= 1'b1;
            blk_valid <= 1'b0;
            blk_first <= 1'b0;
            blk_last  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        mem[idx[5:0]] <= in_data;
                        idx           <= idx + 7'd1;
                        cnt           <= cnt + CNT_W'(1);
                        busy          <= 1'b1;
                        if (idx == 7'd63) begin
                            pad_pend  <= in_last;
                            final_f   <= 1'b0;
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_first <= first_f;
                            blk_last  <= 1'b0;
                        end else if (in_last) begin
                            state    <= PAD80;
                            in_ready <= 1'b0;
                        end
                    end
                end

                PAD80: begin
                    mem[idx[5:0]] <= 8'h80;
                    idx           <= idx + 7'd1;
                    pad_act       <= 1'b1;
                    len_ok        <= (idx <= 7'd55);
                    if (idx == 7'd63) begin
                        final_f   <= 1'b0;
                        state     <= EMIT;
                        blk_valid <= 1'b1;
                        blk_first <= first_f;
                        blk_last  <= 1'b0;
                    end else begin
                        state <= ZERO;
                    end
                end

                ZERO: begin
                    if (len_ok && idx == 7'd56) begin
                        state <= LEN;
                    end else begin
                        mem[idx[5:0]] <= 8'h00;
                        idx           <= idx + 7'd1;
                        if (idx == 7'd63) begin
                            final_f   <= 1'b0;
                            state     <= EMIT;
                            blk_valid <= 1'b1;
                            blk_first <= first_f;
                            blk_last  <= 1'b0;
                        end
                    end
                end

                LEN: begin
                    mem[idx[5:0]] <= len_byte;
                    idx           <= idx + 7'd1;
                    if (idx == 7'd63) begin
                        final_f   <= 1'b1;
                        state     <= EMIT;
                        blk_valid <= 1'b1;
                        blk_first <= first_f;
                        blk_last  <= 1'b1;
                    end
                end

                EMIT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_first <= 1'b0;
                        blk_last  <= 1'b0;
                        idx       <= '0;
                        first_f   <= 1'b0;
                        if (final_f) begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                            cnt      <= '0;
                            first_f  <= 1'b1;
                            busy     <= 1'b0;
                            final_f  <= 1'b0;
                            pad_act  <= 1'b0;
                            len_ok   <= 1'b0;
                        end else if (pad_pend) begin
                            state    <= PAD80;
                            pad_pend <= 1'b0;
                        end else if (pad_act) begin
                            // overflow block: always room for the length now
                            state  <= ZERO;
                            len_ok <= 1'b1;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= FILL;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: known padded blocks for short, boundary
// and block-multiple messages, output back-pressure, and mid-message reset.
module tb_sha_msg_padder;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;
    logic         busy;

    int n_cmp = 0;
    int n_mis = 0;

    sha_msg_padder #(.CNT_W(61)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 512'(in_ready), 512'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_fill(input int len, input logic [7:0] d);
        for (int i = 0; i < len; i++) begin
            send_byte(d, (i == len - 1));
        end
    endtask

    task automatic get_block(output logic [511:0] d, output logic f, output logic l);
        int n;
        n = 0;
        @(negedge clk);
        blk_ready = 1'b1;
        while (blk_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("blk_valid_wait", 512'(blk_valid), 512'(1'b1));
        d = blk_data;
        f = blk_first;
        l = blk_last;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    logic [511:0] got, exp_blk, abc_blk, held;
    logic         gf, gl;

    initial begin
        reset     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;

        abc_blk           = '0;
        abc_blk[511:480]  = 32'h61626380;
        abc_blk[63:0]     = 64'h18;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_blk_valid", 512'(blk_valid), 512'(1'b0));
        chk("rst_blk_first", 512'(blk_first), 512'(1'b0));
        chk("rst_blk_last",  512'(blk_last),  512'(1'b0));
        chk("rst_busy",      512'(busy),      512'(1'b0));
        chk("rst_blk_data",  blk_data,        512'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  512'(in_ready),  512'(1'b1));

        // "abc"
        send_byte(8'h61, 1'b0);
        @(negedge clk);
        chk("abc_busy_set", 512'(busy), 512'(1'b1));
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        @(negedge clk);
        chk("abc_in_ready_low", 512'(in_ready), 512'(1'b0));
        get_block(got, gf, gl);
        chk("abc_data",  got, abc_blk);
        chk("abc_first", 512'(gf), 512'(1'b1));
        chk("abc_last",  512'(gl), 512'(1'b1));
        @(negedge clk);
        chk("abc_busy_clr",  512'(busy),      512'(1'b0));
        chk("abc_valid_clr", 512'(blk_valid), 512'(1'b0));
        chk("abc_in_ready",  512'(in_ready),  512'(1'b1));

        // 55 x 0x41: single block, 0x80 at byte 55
        send_fill(55, 8'h41);
        exp_blk = '0;
        for (int i = 0; i < 55; i++) exp_blk[511-8*i -: 8] = 8'h41;
        exp_blk[511-8*55 -: 8] = 8'h80;
        exp_blk[63:0] = 64'h1B8;
        get_block(got, gf, gl);
        chk("m55_data",  got, exp_blk);
        chk("m55_first", 512'(gf), 512'(1'b1));
        chk("m55_last",  512'(gl), 512'(1'b1));

        // 56 x 0x41: length spills to a second block
        send_fill(56, 8'h41);
        exp_blk = '0;
        for (int i = 0; i < 56; i++) exp_blk[511-8*i -: 8] = 8'h41;
        exp_blk[511-8*56 -: 8] = 8'h80;
        get_block(got, gf, gl);
        chk("m56_b0_data",  got, exp_blk);
        chk("m56_b0_first", 512'(gf), 512'(1'b1));
        chk("m56_b0_last",  512'(gl), 512'(1'b0));
        exp_blk = '0;
        exp_blk[63:0] = 64'h1C0;
        get_block(got, gf, gl);
        chk("m56_b1_data",  got, exp_blk);
        chk("m56_b1_first", 512'(gf), 512'(1'b0));
        chk("m56_b1_last",  512'(gl), 512'(1'b1));

        // 64 x 0x00: full data block then a block starting with 0x80
        send_fill(64, 8'h00);
        get_block(got, gf, gl);
        chk("m64_b0_data",  got, 512'(0));
        chk("m64_b0_first", 512'(gf), 512'(1'b1));
        chk("m64_b0_last",  512'(gl), 512'(1'b0));
        exp_blk = '0;
        exp_blk[511:504] = 8'h80;
        exp_blk[63:0] = 64'h200;
        get_block(got, gf, gl);
        chk("m64_b1_data",  got, exp_blk);
        chk("m64_b1_first", 512'(gf), 512'(1'b0));
        chk("m64_b1_last",  512'(gl), 512'(1'b1));

        // "abc" with core stalling 10 cycles
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        begin
            int n;
            n = 0;
            while (blk_valid !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("stall_valid_seen", 512'(blk_valid), 512'(1'b1));
        held = blk_data;
        chk("stall_data_initial", held, abc_blk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_valid",    512'(blk_valid), 512'(1'b1));
            chk("stall_data",     blk_data,        abc_blk);
            chk("stall_in_ready", 512'(in_ready),  512'(1'b0));
        end
        get_block(got, gf, gl);
        chk("stall_accept_data", got, abc_blk);
        chk("stall_accept_last", 512'(gl), 512'(1'b1));

        // reset while padding message A, then "abc"
        send_fill(10, 8'h55);
        repeat (5) @(negedge clk);
        chk("ra_busy_before", 512'(busy), 512'(1'b1));
        reset = 1'b0;
        #1;
        chk("ra_rst_valid", 512'(blk_valid), 512'(1'b0));
        chk("ra_rst_busy",  512'(busy),      512'(1'b0));
        chk("ra_rst_data",  blk_data,        512'(0));
        chk("ra_rst_first", 512'(blk_first), 512'(1'b0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        get_block(got, gf, gl);
        chk("ra_abc_data",  got, abc_blk);
        chk("ra_abc_first", 512'(gf), 512'(1'b1));
        chk("ra_abc_last",  512'(gl), 512'(1'b1));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
